// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the pipeline hazard unit: forwarding selects, FSM states
// and the default register-address width.
package hazard_unit_pkg;

  localparam int unsigned REG_AW_DEFAULT = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_ABORT = 1'b1
  } state_e;

endpackage

// File: rtl/hazard_unit_match.sv
// Single stage/source comparator: the stage holds a live register write to the
// register the ID instruction actually reads (x0 never matches).
module hazard_match
  import hazard_unit_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEFAULT
) (
  input  logic              valid,
  input  logic              regwrite,
  input  logic [REG_AW-1:0] rd,
  input  logic              use_rs,
  input  logic [REG_AW-1:0] rs,
  output logic              match
);

  assign match = valid & regwrite & (rd != '0) & (rd == rs) & use_rs;

endmodule

// File: rtl/hazard_unit.sv
// Five-stage pipeline control: interlock, redirect squash, data-memory stall with
// timeout abort, forwarding selects and perf counters. Define FORWARD_EN for bypassing.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int unsigned REG_AW      = REG_AW_DEFAULT,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              ex_regwrite,
  input  logic              mem_regwrite,
  input  logic              wb_regwrite,
  input  logic              ex_is_load,
  input  logic              ex_redirect,
  input  logic              dmem_req,
  input  logic              dmem_ready,
  output logic              pc_we,
  output logic              if_id_we,
  output logic              id_ex_we,
  output logic              ex_mem_we,
  output logic              mem_wb_we,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              ex_mem_flush,
  output logic              mem_wb_flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              valid_id,
  output logic              valid_ex,
  output logic              valid_mem,
  output logic              valid_wb,
  output logic              mem_err,
  output logic [CNT_W-1:0]  retired,
  output logic [CNT_W-1:0]  stalls
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_e            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              v_id, v_ex, v_mem, v_wb;

  // hit[2*stage + source]; stage 0=EX 1=MEM 2=WB, source 0=rs1 1=rs2
  logic [5:0]        hit;
  logic [2:0]        st_valid, st_rw;
  logic [REG_AW-1:0] st_rd [3];
  logic [REG_AW-1:0] src [2];
  logic [1:0]        src_use;
  logic              memstall, redirect, interlock;

  // The aborted MEM instruction is treated as gone during the ABORT cycle.
  assign valid_id  = v_id;
  assign valid_ex  = v_ex;
  assign valid_mem = v_mem & (state == ST_RUN);
  assign valid_wb  = v_wb;

  assign st_valid = {valid_wb, valid_mem, valid_ex};
  assign st_rw    = {wb_regwrite, mem_regwrite, ex_regwrite};
  assign st_rd[0] = ex_rd;
  assign st_rd[1] = mem_rd;
  assign st_rd[2] = wb_rd;
  assign src[0]   = id_rs1;
  assign src[1]   = id_rs2;
  assign src_use  = {id_use_rs2, id_use_rs1};

  for (genvar s = 0; s < 3; s++) begin : g_stage
    for (genvar r = 0; r < 2; r++) begin : g_src
      hazard_match #(
        .REG_AW(REG_AW)
      ) u_match (
        .valid   (st_valid[s]),
        .regwrite(st_rw[s]),
        .rd      (st_rd[s]),
        .use_rs  (src_use[r]),
        .rs      (src[r]),
        .match   (hit[2*s+r])
      );
    end
  end

`ifdef FORWARD_EN
  assign interlock = ex_is_load & (hit[0] | hit[1]);

  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (hit[2])      fwd_a = FWD_MEM;
    else if (hit[4]) fwd_a = FWD_WB;
    if (hit[3])      fwd_b = FWD_MEM;
    else if (hit[5]) fwd_b = FWD_WB;
  end
`else
  // Regfile writes on the clock edge, so a WB producer is not yet readable in ID.
  assign interlock = |hit;
  assign fwd_a     = FWD_RF;
  assign fwd_b     = FWD_RF;
`endif

  assign memstall = valid_mem & dmem_req & ~dmem_ready & (state == ST_RUN);
  assign redirect = ex_redirect & valid_ex;

  always_comb begin
    pc_we        = 1'b1;
    if_id_we     = 1'b1;
    id_ex_we     = 1'b1;
    ex_mem_we    = 1'b1;
    mem_wb_we    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    if (memstall) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_we     = 1'b0;
      ex_mem_we    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (interlock) begin
      pc_we       = 1'b0;
      if_id_we    = 1'b0;
      id_ex_flush = 1'b1;
    end
    if (state == ST_ABORT) begin
      ex_mem_we    = 1'b1;
      ex_mem_flush = 1'b0;
      mem_wb_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (memstall) begin
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) state <= ST_ABORT;
          end else begin
            wait_cnt <= '0;
          end
        end
        ST_ABORT: begin
          state    <= ST_RUN;
          wait_cnt <= '0;
          mem_err  <= 1'b1;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_id    <= 1'b0;
      v_ex    <= 1'b0;
      v_mem   <= 1'b0;
      v_wb    <= 1'b0;
      retired <= '0;
      stalls  <= '0;
    end else begin
      if (if_id_flush)       v_id <= 1'b0;
      else if (if_id_we)     v_id <= fetch_valid;
      if (id_ex_flush)       v_ex <= 1'b0;
      else if (id_ex_we)     v_ex <= valid_id;
      if (ex_mem_flush)      v_mem <= 1'b0;
      else if (ex_mem_we)    v_mem <= valid_ex;
      if (mem_wb_flush)      v_wb <= 1'b0;
      else if (mem_wb_we)    v_wb <= valid_mem;
      if (valid_wb) retired <= retired + 1'b1;
      if (!pc_we)   stalls  <= stalls + 1'b1;
    end
  end

endmodule
